// File: rtl/ascon_aead128_pkg.sv
// Shared types and constants for the Ascon-AEAD128 sequencing controller.
// All select encodings are chosen so that 0 is the idle/default value.
package ascon_aead128_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_STARTUP,
    ST_INIT,
    ST_TRANS1,
    ST_XOR_AD1,
    ST_XOR_AD2,
    ST_P8_AD1,
    ST_P8_AD2,
    ST_TRANS2,
    ST_XOR_DB1,
    ST_XOR_DB2,
    ST_P8_DB,
    ST_TRANS3,
    ST_XOR_FIN,
    ST_FINAL,
    ST_TAG
  } ascon_fsm_state;

  typedef logic [3:0] round_t;

  typedef enum logic {
    P8_MODE  = 1'b0,
    P12_MODE = 1'b1
  } round_mode_t;

  localparam round_t P8_INIT    = 4'd8;
  localparam round_t P12_INIT   = 4'd4;
  localparam round_t INCR       = 4'd1;
  localparam round_t LAST_ROUND = 4'hF;

  localparam logic SEL_LOOP_STATE  = 1'b0;
  localparam logic SEL_INPUT_STATE = 1'b1;
  localparam logic SEL_AD          = 1'b0;
  localparam logic SEL_DB          = 1'b1;
  localparam logic SEL_DATA_NO_XOR = 1'b0;
  localparam logic SEL_DATA_XOR    = 1'b1;
  localparam logic SEL_DATA        = 1'b0;
  localparam logic SEL_TAG         = 1'b1;
  localparam logic SEL_NO_DSEP     = 1'b0;
  localparam logic SEL_DSEP        = 1'b1;

  localparam logic [1:0] SEL_KEY_NO_XOR = 2'd0;
  localparam logic [1:0] SEL_0_KEY      = 2'd1;
  localparam logic [1:0] SEL_KEY_0      = 2'd2;
  localparam logic [1:0] SEL_KEY_KEY    = 2'd3;

  function automatic logic is_perm_state(input ascon_fsm_state s);
    return (s == ST_INIT) || (s == ST_P8_AD1) || (s == ST_P8_AD2) ||
           (s == ST_P8_DB) || (s == ST_FINAL);
  endfunction

endpackage

// File: rtl/ascon_round_counter.sv
// Round index for constant addition: loads the first round of a p8/p12 run,
// steps once per applied round and saturates at the last round.
module ascon_round_counter
  import ascon_aead128_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  round_mode_t i_mode,
  input  logic        i_load,
  input  logic        i_incr,
  output round_t      o_round,
  output logic        o_last
);

  round_t r_round;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_round <= '0;
    end else if (i_load) begin
      r_round <= (i_mode == P12_MODE) ? P12_INIT : P8_INIT;
    end else if (i_incr && (r_round != LAST_ROUND)) begin
      r_round <= r_round + INCR;
    end
  end

  assign o_round = r_round;
  assign o_last  = (r_round == LAST_ROUND);

endmodule

// File: rtl/ascon_aead128_ctrl.sv
// Ascon-AEAD128 sequencing controller: FSM plus output decode driving the
// datapath selects, permutation enable and round index.
module ascon_aead128_ctrl
  import ascon_aead128_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_start,
  input  logic           i_decrypt,
  input  logic           i_has_ad,
  output logic           o_ready,
  input  logic           i_ad_valid,
  input  logic           i_ad_last,
  output logic           o_ad_ready,
  input  logic           i_db_valid,
  input  logic           i_db_last,
  output logic           o_db_ready,
  output logic           o_dout_valid,
  input  logic           i_dout_ready,
  output logic           o_tag_valid,
  input  logic           i_tag_ready,
  output logic           o_sel_state,
  output logic           o_sel_din,
  output logic           o_sel_xor_data,
  output logic [1:0]     o_sel_xor_key,
  output logic           o_sel_dout,
  output logic           o_sel_dsep,
  output logic           o_perm_en,
  output logic [3:0]     o_round,
  output logic           o_decrypt_o,
  output ascon_fsm_state o_state
);

  localparam round_t PRE_LAST_ROUND = LAST_ROUND - INCR;

  ascon_fsm_state r_state, w_state_nxt;
  logic        r_has_ad, r_decrypt;
  logic        r_ready, r_ad_ready, r_in_db, r_tag_valid, r_perm_en;
  logic        r_sel_state, r_sel_din, r_sel_dout, r_sel_dsep;
  logic [1:0]  r_sel_xor_key;
  logic        w_ad_hs, w_db_hs, w_tag_hs, w_load, w_last, w_key_last;
  round_mode_t w_mode;
  round_t      w_round;

  // Handshakes: a transfer happens in a cycle where valid and ready are both
  // high. The data path is a pass-through: dout_valid follows db_valid and
  // db_ready follows dout_ready, so a block moves only when both ends agree.
  assign w_ad_hs  = r_ad_ready & i_ad_valid;
  assign w_db_hs  = r_in_db & i_db_valid & i_dout_ready;
  assign w_tag_hs = r_tag_valid & i_tag_ready;

  assign w_load = (r_state == ST_STARTUP) || (r_state == ST_XOR_FIN) ||
                  w_ad_hs || (w_db_hs && !i_db_last);
  assign w_mode = ((r_state == ST_STARTUP) || (r_state == ST_XOR_FIN)) ? P12_MODE : P8_MODE;

  ascon_round_counter u_round_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_mode  (w_mode),
    .i_load  (w_load),
    .i_incr  (r_perm_en),
    .o_round (w_round),
    .o_last  (w_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:                if (i_start && r_ready) w_state_nxt = ST_STARTUP;
      ST_STARTUP:             w_state_nxt = ST_INIT;
      ST_INIT:                if (w_last) w_state_nxt = ST_TRANS1;
      ST_TRANS1:              w_state_nxt = r_has_ad ? ST_XOR_AD1 : ST_TRANS2;
      ST_XOR_AD1, ST_XOR_AD2: if (w_ad_hs) w_state_nxt = i_ad_last ? ST_P8_AD2 : ST_P8_AD1;
      ST_P8_AD1:              if (w_last) w_state_nxt = ST_XOR_AD2;
      ST_P8_AD2:              if (w_last) w_state_nxt = ST_TRANS2;
      ST_TRANS2:              w_state_nxt = ST_XOR_DB1;
      ST_XOR_DB1, ST_XOR_DB2: if (w_db_hs) w_state_nxt = i_db_last ? ST_TRANS3 : ST_P8_DB;
      ST_P8_DB:               if (w_last) w_state_nxt = ST_XOR_DB2;
      ST_TRANS3:              w_state_nxt = ST_XOR_FIN;
      ST_XOR_FIN:             w_state_nxt = ST_FINAL;
      ST_FINAL:               if (w_last) w_state_nxt = ST_TAG;
      ST_TAG:                 if (w_tag_hs) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state
  // register; the key xor in the last round is anticipated one round early.
  assign w_key_last = ((r_state == ST_INIT) || (r_state == ST_FINAL)) &&
                      (w_state_nxt == r_state) && (w_round == PRE_LAST_ROUND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_has_ad      <= 1'b0;
      r_decrypt     <= 1'b0;
      r_ready       <= 1'b0;
      r_ad_ready    <= 1'b0;
      r_in_db       <= 1'b0;
      r_tag_valid   <= 1'b0;
      r_perm_en     <= 1'b0;
      r_sel_state   <= SEL_LOOP_STATE;
      r_sel_din     <= SEL_AD;
      r_sel_dout    <= SEL_DATA;
      r_sel_dsep    <= SEL_NO_DSEP;
      r_sel_xor_key <= SEL_KEY_NO_XOR;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && i_start && r_ready) begin
        r_has_ad  <= i_has_ad;
        r_decrypt <= i_decrypt;
      end
      r_ready       <= (w_state_nxt == ST_IDLE);
      r_ad_ready    <= (w_state_nxt == ST_XOR_AD1) || (w_state_nxt == ST_XOR_AD2);
      r_in_db       <= (w_state_nxt == ST_XOR_DB1) || (w_state_nxt == ST_XOR_DB2);
      r_tag_valid   <= (w_state_nxt == ST_TAG);
      r_perm_en     <= is_perm_state(w_state_nxt);
      r_sel_state   <= (w_state_nxt == ST_STARTUP) ? SEL_INPUT_STATE : SEL_LOOP_STATE;
      r_sel_din     <= ((w_state_nxt == ST_XOR_DB1) || (w_state_nxt == ST_XOR_DB2)) ? SEL_DB : SEL_AD;
      r_sel_dout    <= (w_state_nxt == ST_TAG) ? SEL_TAG : SEL_DATA;
      r_sel_dsep    <= (w_state_nxt == ST_TRANS2) ? SEL_DSEP : SEL_NO_DSEP;
      r_sel_xor_key <= (w_state_nxt == ST_XOR_FIN) ? SEL_KEY_0 :
                       (w_key_last ? SEL_0_KEY : SEL_KEY_NO_XOR);
    end
  end

  assign o_ready        = r_ready;
  assign o_ad_ready     = r_ad_ready;
  assign o_db_ready     = r_in_db & i_dout_ready;
  assign o_dout_valid   = r_in_db & i_db_valid;
  assign o_tag_valid    = r_tag_valid;
  assign o_sel_state    = r_sel_state;
  assign o_sel_din      = r_sel_din;
  assign o_sel_xor_data = (w_ad_hs || w_db_hs) ? SEL_DATA_XOR : SEL_DATA_NO_XOR;
  assign o_sel_xor_key  = r_sel_xor_key;
  assign o_sel_dout     = r_sel_dout;
  assign o_sel_dsep     = r_sel_dsep;
  assign o_perm_en      = r_perm_en;
  assign o_round        = w_round;
  assign o_decrypt_o    = r_decrypt;
  assign o_state        = r_state;

endmodule

// File: tb/tb_ascon_aead128_ctrl.sv
// Directed bench for ascon_aead128_ctrl: cycle-indexed operations with
// hand-derived latencies, round sequences and select timing.
module tb_ascon_aead128_ctrl;
  import ascon_aead128_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_start = 0, i_decrypt = 0, i_has_ad = 0;
  logic i_ad_valid = 0, i_ad_last = 0, i_db_valid = 0, i_db_last = 0;
  logic i_dout_ready = 0, i_tag_ready = 0;
  logic o_ready, o_ad_ready, o_db_ready, o_dout_valid, o_tag_valid;
  logic o_sel_state, o_sel_din, o_sel_xor_data, o_sel_dout, o_sel_dsep, o_perm_en, o_decrypt_o;
  logic [1:0] o_sel_xor_key;
  logic [3:0] o_round;
  ascon_fsm_state o_state;

  int checks = 0;
  int failures = 0;

  // per-operation observations
  int tag_first, tag_cycles, ready_cycle, db_ready_cycles, db_first, db_hs_cycle;
  int ad_hs, dsep_cnt, dsep_cycle, sel_state_cycle, key0_cycle, early_rdy;
  int abort_round;
  logic dec_seen;
  ascon_fsm_state abort_state;
  logic [3:0] round_q[$];
  logic [3:0] exp_q[$];
  int key01_q[$];

  always #5 clk = ~clk;

  ascon_aead128_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_decrypt(i_decrypt), .i_has_ad(i_has_ad),
    .o_ready(o_ready), .i_ad_valid(i_ad_valid), .i_ad_last(i_ad_last), .o_ad_ready(o_ad_ready),
    .i_db_valid(i_db_valid), .i_db_last(i_db_last), .o_db_ready(o_db_ready),
    .o_dout_valid(o_dout_valid), .i_dout_ready(i_dout_ready),
    .o_tag_valid(o_tag_valid), .i_tag_ready(i_tag_ready),
    .o_sel_state(o_sel_state), .o_sel_din(o_sel_din), .o_sel_xor_data(o_sel_xor_data),
    .o_sel_xor_key(o_sel_xor_key), .o_sel_dout(o_sel_dout), .o_sel_dsep(o_sel_dsep),
    .o_perm_en(o_perm_en), .o_round(o_round), .o_decrypt_o(o_decrypt_o), .o_state(o_state)
  );

  function automatic int exp_tag(input int n_ad, input int n_db, input int stall);
    return 31 + 9 * n_ad + 9 * (n_db - 1) + stall;
  endfunction

  // init p12, one p8 per AD block, one p8 per non-last data block, final p12
  function automatic void build_exp(input int n_ad, input int n_db);
    exp_q.delete();
    for (int r = 4; r <= 15; r++) exp_q.push_back(4'(r));
    for (int b = 0; b < n_ad + n_db - 1; b++)
      for (int r = 8; r <= 15; r++) exp_q.push_back(4'(r));
    for (int r = 4; r <= 15; r++) exp_q.push_back(4'(r));
  endfunction

  function automatic int rounds_diff();
    int d = 0;
    if (round_q.size() != exp_q.size()) return 1000 + round_q.size();
    foreach (exp_q[k]) if (round_q[k] !== exp_q[k]) d++;
    return d;
  endfunction

  task automatic drive_idle();
    i_start = 0; i_ad_valid = 0; i_ad_last = 0; i_db_valid = 0; i_db_last = 0;
    i_dout_ready = 0; i_tag_ready = 0;
  endtask

  // Runs one operation; cycle 0 is the cycle in which start is accepted.
  task automatic run_op(input logic dec, input int n_ad, input int n_db,
                        input int db_hold_from, input int db_hold_len,
                        input int tag_hold_from, input int tag_hold_len,
                        input bit noise, input int abort_cycle);
    int c = 0;
    int ad_sent = 0;
    int db_sent = 0;
    bit tag_done = 0;
    bit done = 0;
    bit aborted = 0;
    bit in_noise;
    tag_first = -1; tag_cycles = 0; ready_cycle = -1; db_ready_cycles = 0; db_first = -1;
    db_hs_cycle = -1; ad_hs = 0; dsep_cnt = 0; dsep_cycle = -1; sel_state_cycle = -1;
    key0_cycle = -1; early_rdy = 0; abort_round = -1; dec_seen = 1'bx;
    round_q.delete(); key01_q.delete();
    while (!done && c < 300) begin
      @(negedge clk);
      in_noise = noise && (c >= 2) && (c <= 13);
      i_start = (c == 0) || in_noise;
      i_decrypt = dec;
      i_has_ad = (n_ad > 0);
      i_ad_valid = (ad_sent < n_ad) || in_noise;
      i_ad_last = (ad_sent == n_ad - 1);
      i_db_valid = ((db_sent < n_db) && !(c >= db_hold_from && c < db_hold_from + db_hold_len)) || in_noise;
      i_db_last = (db_sent == n_db - 1);
      i_dout_ready = 1'b1;
      i_tag_ready = !(c >= tag_hold_from && c < tag_hold_from + tag_hold_len);
      #1;
      if (c == abort_cycle) begin
        abort_round = o_round;
        abort_state = o_state;
        aborted = 1;
        break;
      end
      if (c == 1) dec_seen = o_decrypt_o;
      if (c >= 1 && c <= 13 && (o_ad_ready || o_db_ready)) early_rdy++;
      if (o_ad_ready && i_ad_valid) begin ad_sent++; ad_hs++; end
      if (o_db_ready) begin
        db_ready_cycles++;
        if (db_first < 0) db_first = c;
      end
      if (o_dout_valid && i_dout_ready) begin db_sent++; db_hs_cycle = c; end
      if (o_perm_en) round_q.push_back(o_round);
      if (o_sel_dsep) begin dsep_cnt++; dsep_cycle = c; end
      if (o_sel_state == SEL_INPUT_STATE) sel_state_cycle = c;
      if (o_sel_xor_key == SEL_0_KEY) key01_q.push_back(c);
      if (o_sel_xor_key == SEL_KEY_0) key0_cycle = c;
      if (tag_done && o_ready) begin ready_cycle = c; done = 1; end
      if (o_tag_valid) begin
        tag_cycles++;
        if (tag_first < 0) tag_first = c;
        if (i_tag_ready) tag_done = 1;
      end
      c++;
    end
    drive_idle();
    if (!done && !aborted) begin
      checks++; failures++;
      $display("FAIL op_timeout: got no completion after %0d cycles, required completion", c);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] outs;
    #1;
    outs = {o_ready, o_ad_ready, o_db_ready, o_dout_valid, o_tag_valid, o_sel_state, o_sel_din,
            o_sel_xor_data, o_sel_xor_key, o_sel_dout, o_sel_dsep, o_perm_en, o_round, o_decrypt_o};
    checks++; if (outs !== 18'd0) begin failures++; $display("FAIL reset_outs: got %h expected 0", outs); end
    checks++; if (o_state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", o_state, ST_IDLE); end
    release_reset();
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready: got %b expected 1", o_ready); end
    checks++; if (o_round !== 4'd0) begin failures++; $display("FAIL post_reset_round: got %0d expected 0", o_round); end
    // start an operation and pull reset low mid-cycle during initialisation
    run_op(1'b1, 0, 1, -1, 0, -1, 0, 1'b0, 6);
    checks++; if (abort_round !== 8) begin failures++; $display("FAIL init_round_c6: got %0d expected 8", abort_round); end
    #1 rst_n = 1'b0;
    #1;
    outs = {o_ready, o_ad_ready, o_db_ready, o_dout_valid, o_tag_valid, o_sel_state, o_sel_din,
            o_sel_xor_data, o_sel_xor_key, o_sel_dout, o_sel_dsep, o_perm_en, o_round, o_decrypt_o};
    checks++; if (outs !== 18'd0) begin failures++; $display("FAIL async_reset_outs: got %h expected 0", outs); end
    checks++; if (o_state !== ST_IDLE) begin failures++; $display("FAIL async_reset_state: got %0d expected %0d", o_state, ST_IDLE); end
    release_reset();
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL rerelease_ready: got %b expected 1", o_ready); end
  endtask

  task automatic test_encrypt_single();
    run_op(1'b0, 0, 1, -1, 0, -1, 0, 1'b0, -1);
    build_exp(0, 1);
    checks++; if (tag_first !== 31) begin failures++; $display("FAIL enc1_tag_cycle: got %0d expected 31", tag_first); end
    checks++; if (ready_cycle !== 32) begin failures++; $display("FAIL enc1_ready_cycle: got %0d expected 32", ready_cycle); end
    checks++; if (db_ready_cycles !== 1) begin failures++; $display("FAIL enc1_db_ready_len: got %0d expected 1", db_ready_cycles); end
    checks++; if (db_first !== 16) begin failures++; $display("FAIL enc1_db_ready_cycle: got %0d expected 16", db_first); end
    checks++; if (rounds_diff() !== 0) begin failures++; $display("FAIL enc1_rounds: got %0d diffs expected 0 (len %0d)", rounds_diff(), round_q.size()); end
    checks++; if (sel_state_cycle !== 1) begin failures++; $display("FAIL enc1_sel_state: got %0d expected 1", sel_state_cycle); end
    checks++; if (dsep_cnt !== 1 || dsep_cycle !== 15) begin failures++; $display("FAIL enc1_dsep: got %0d@%0d expected 1@15", dsep_cnt, dsep_cycle); end
    checks++; if (key01_q.size() !== 2 || key01_q[0] !== 13 || key01_q[1] !== 30) begin
      failures++; $display("FAIL enc1_key_0key: got %0d entries expected cycles 13,30", key01_q.size()); end
    checks++; if (key0_cycle !== 18) begin failures++; $display("FAIL enc1_key_key0: got %0d expected 18", key0_cycle); end
    checks++; if (dec_seen !== 1'b0) begin failures++; $display("FAIL enc1_decrypt_o: got %b expected 0", dec_seen); end
  endtask

  task automatic test_ad_and_data();
    run_op(1'b0, 2, 2, -1, 0, -1, 0, 1'b0, -1);
    build_exp(2, 2);
    checks++; if (tag_first !== exp_tag(2, 2, 0)) begin failures++; $display("FAIL ad2db2_tag_cycle: got %0d expected %0d", tag_first, exp_tag(2, 2, 0)); end
    checks++; if (tag_first !== 58) begin failures++; $display("FAIL ad2db2_tag_58: got %0d expected 58", tag_first); end
    checks++; if (dsep_cnt !== 1 || dsep_cycle !== 33) begin failures++; $display("FAIL ad2db2_dsep: got %0d@%0d expected 1@33", dsep_cnt, dsep_cycle); end
    checks++; if (rounds_diff() !== 0) begin failures++; $display("FAIL ad2db2_rounds: got %0d diffs expected 0 (len %0d)", rounds_diff(), round_q.size()); end
    checks++; if (ad_hs !== 2) begin failures++; $display("FAIL ad2db2_ad_hs: got %0d expected 2", ad_hs); end
    checks++; if (db_hs_cycle !== 43) begin failures++; $display("FAIL ad2db2_last_db: got %0d expected 43", db_hs_cycle); end
    checks++; if (key01_q.size() !== 2 || key01_q[1] !== 57) begin failures++; $display("FAIL ad2db2_key_0key: got %0d entries expected final at 57", key01_q.size()); end
  endtask

  task automatic test_backpressure();
    run_op(1'b0, 0, 1, 16, 5, 36, 3, 1'b0, -1);
    build_exp(0, 1);
    checks++; if (tag_first !== 36) begin failures++; $display("FAIL bp_tag_cycle: got %0d expected 36", tag_first); end
    checks++; if (db_hs_cycle !== 21) begin failures++; $display("FAIL bp_db_hs: got %0d expected 21", db_hs_cycle); end
    checks++; if (db_ready_cycles !== 6) begin failures++; $display("FAIL bp_db_ready_len: got %0d expected 6", db_ready_cycles); end
    checks++; if (rounds_diff() !== 0) begin failures++; $display("FAIL bp_rounds: got %0d diffs expected 0", rounds_diff()); end
    checks++; if (tag_cycles !== 4) begin failures++; $display("FAIL bp_tag_held: got %0d expected 4", tag_cycles); end
    checks++; if (ready_cycle !== 40) begin failures++; $display("FAIL bp_ready_cycle: got %0d expected 40", ready_cycle); end
  endtask

  task automatic test_abort_and_decrypt();
    int tag_seen = 0;
    run_op(1'b0, 0, 1, -1, 0, -1, 0, 1'b0, 24);
    checks++; if (abort_round !== 9) begin failures++; $display("FAIL abort_round: got %0d expected 9", abort_round); end
    checks++; if (abort_state !== ST_FINAL) begin failures++; $display("FAIL abort_state: got %0d expected %0d", abort_state, ST_FINAL); end
    checks++; if (tag_first !== -1) begin failures++; $display("FAIL abort_tag_pre: got %0d expected -1", tag_first); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (o_state !== ST_IDLE || o_perm_en !== 1'b0) begin failures++; $display("FAIL abort_idle: got %0d/%b expected %0d/0", o_state, o_perm_en, ST_IDLE); end
    release_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (o_tag_valid) tag_seen++;
    end
    checks++; if (tag_seen !== 0) begin failures++; $display("FAIL abort_no_tag: got %0d expected 0", tag_seen); end
    run_op(1'b1, 0, 1, -1, 0, -1, 0, 1'b0, -1);
    checks++; if (dec_seen !== 1'b1) begin failures++; $display("FAIL dec_decrypt_o: got %b expected 1", dec_seen); end
    checks++; if (tag_first !== 31) begin failures++; $display("FAIL dec_tag_cycle: got %0d expected 31", tag_first); end
  endtask

  task automatic test_ignored_inputs();
    run_op(1'b0, 0, 1, -1, 0, -1, 0, 1'b1, -1);
    build_exp(0, 1);
    checks++; if (early_rdy !== 0) begin failures++; $display("FAIL noise_early_ready: got %0d expected 0", early_rdy); end
    checks++; if (ad_hs !== 0) begin failures++; $display("FAIL noise_ad_hs: got %0d expected 0", ad_hs); end
    checks++; if (rounds_diff() !== 0) begin failures++; $display("FAIL noise_rounds: got %0d diffs expected 0", rounds_diff()); end
    checks++; if (tag_first !== 31 || ready_cycle !== 32) begin failures++; $display("FAIL noise_timing: got %0d/%0d expected 31/32", tag_first, ready_cycle); end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_encrypt_single();
    test_ad_and_data();
    test_backpressure();
    test_abort_and_decrypt();
    test_ignored_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
